// File: rtl/rast_sched_pkg.sv
// Shared types and constants for the rasterizer front-end triangle scheduler.
package rast_sched_pkg;
  localparam int P_SIGFIG = 24;
  localparam int P_VERTS  = 3;
  localparam int P_AXIS   = 3;
  localparam int P_COLORS = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam int P_SCR_X = 1280 << 10;
  localparam int P_SCR_Y = 720 << 10;
  localparam logic [2*P_SIGFIG-1:0] DEF_SCREEN = {P_SIGFIG'(P_SCR_X), P_SIGFIG'(P_SCR_Y)};
  localparam logic [3:0] DEF_SUBSAMPLE = 4'b1000;

  typedef logic signed [P_VERTS*P_AXIS*P_SIGFIG-1:0] tri_t;
  typedef logic [P_COLORS*P_SIGFIG-1:0] color_t;
endpackage

// File: rtl/rast_tri_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   next_ptr
);
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    // Outer loop walks priority order starting at ptr; inner loop keeps indices constant.
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (en && !found && req[k] && (k == ((int'(ptr) + i) % NREQ))) begin
          grant[k] = 1'b1;
          next_ptr = PW'((k + 1) % NREQ);
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/rast_tri_sched.sv
// Front-end scheduler: round-robin feeds the R10 triangle port and drains the pipe before
// applying screen/subsample changes.
module rast_tri_sched
  import rast_sched_pkg::*;
#(
  parameter int SIGFIG     = P_SIGFIG,
  parameter int VERTS      = P_VERTS,
  parameter int AXIS       = P_AXIS,
  parameter int COLORS     = P_COLORS,
  parameter int NREQ       = 2,
  parameter int PIPE_DRAIN = 8,
  parameter int CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*VERTS*AXIS*SIGFIG-1:0] req_tri,
  input  logic [NREQ*COLORS*SIGFIG-1:0]     req_color,
  output logic [NREQ-1:0]                   req_ready,
  input  logic                              cfg_req,
  input  logic [2*SIGFIG-1:0]               cfg_screen,
  input  logic [3:0]                        cfg_subsample,
  output logic                              cfg_ack,
  input  logic                              halt_RnnnnL,
  output logic [VERTS*AXIS*SIGFIG-1:0]      tri_R10S,
  output logic [COLORS*SIGFIG-1:0]          color_R10U,
  output logic                              validTri_R10H,
  output logic [2*SIGFIG-1:0]               screen_RnnnnS,
  output logic [3:0]                        subSample_RnnnnU,
  output logic                              busy_H,
  output logic [CNT_W-1:0]                  tri_count,
  output state_e                            dbg_state
);
  localparam int TW = VERTS * AXIS * SIGFIG;
  localparam int CW = COLORS * SIGFIG;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (PIPE_DRAIN > 0) ? $clog2(PIPE_DRAIN + 1) : 1;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [TW-1:0]       tri_q, tri_d;
  logic [CW-1:0]       color_q, color_d;
  logic [2*SIGFIG-1:0] screen_q, screen_d;
  logic [3:0]          sub_q, sub_d;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic                armed_q;

  logic                ld, accept, grant_en;
  logic [NREQ-1:0]     grant;
  logic [PW-1:0]       next_ptr;
  logic [TW-1:0]       win_tri;
  logic [CW-1:0]       win_color;

  // Handshake: req_valid[i] & req_ready[i] in the same cycle transfers requester i's triangle;
  // on R10, validTri_R10H & halt_RnnnnL at an edge hands the triangle to the rasterizer.
  // armed_q keeps req_ready low while reset is asserted.
  assign ld       = !valid_q || halt_RnnnnL;
  assign accept   = valid_q && halt_RnnnnL;
  assign grant_en = armed_q && (state_q == RUN) && ld && !cfg_req;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .en       (grant_en),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_comb begin
    win_tri   = '0;
    win_color = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_tri   = req_tri[i*TW +: TW];
        win_color = req_color[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    tri_d    = tri_q;
    color_d  = color_q;
    screen_d = screen_q;
    sub_d    = sub_q;
    ack_d    = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q + CNT_W'(accept);
    drain_d  = drain_q;

    if (ld) begin
      valid_d = |grant;
      if (|grant) begin
        tri_d   = win_tri;
        color_d = win_color;
        ptr_d   = next_ptr;
      end
    end

    if (accept) drain_d = DW'(PIPE_DRAIN);
    else if (halt_RnnnnL && (drain_q != '0)) drain_d = drain_q - DW'(1);

    case (state_q)
      RUN:    if (cfg_req) state_d = DRAIN;
      DRAIN: begin
        if (!valid_q && (drain_q == '0)) begin
          state_d = UPDATE;
          ack_d   = 1'b1;
        end
      end
      UPDATE: begin
        state_d  = RUN;
        screen_d = cfg_screen;
        sub_d    = cfg_subsample;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      tri_q    <= '0;
      color_q  <= '0;
      screen_q <= {SIGFIG'(P_SCR_X), SIGFIG'(P_SCR_Y)};
      sub_q    <= DEF_SUBSAMPLE;
      ack_q    <= 1'b0;
      cnt_q    <= '0;
      drain_q  <= '0;
      ptr_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
      screen_q <= screen_d;
      sub_q    <= sub_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      ptr_q    <= ptr_d;
      armed_q  <= 1'b1;
    end
  end

  assign req_ready        = grant;
  assign tri_R10S         = tri_q;
  assign color_R10U       = color_q;
  assign validTri_R10H    = valid_q;
  assign screen_RnnnnS    = screen_q;
  assign subSample_RnnnnU = sub_q;
  assign cfg_ack          = ack_q;
  assign tri_count        = cnt_q;
  assign busy_H           = (state_q != RUN) || (drain_q != '0);
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_rast_tri_sched.sv
// Directed bench for rast_tri_sched: vector table for arbitration/collision plus
// hand sequences for reset, backpressure and config drain.
module tb_rast_tri_sched;
  import rast_sched_pkg::*;

  localparam int TW = 216;
  localparam int CW = 72;
  localparam logic [47:0] SCR_DEF = {24'd1310720, 24'd737280};
  localparam logic [47:0] SCR_A   = 48'h0C8000_096000;
  localparam logic [47:0] SCR_B   = 48'h050000_03C000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [2*TW-1:0] req_tri;
  logic [2*CW-1:0] req_color;
  logic [1:0]      req_ready;
  logic            cfg_req;
  logic [47:0]     cfg_screen;
  logic [3:0]      cfg_subsample;
  logic            cfg_ack;
  logic            halt_RnnnnL;
  logic [TW-1:0]   tri_R10S;
  logic [CW-1:0]   color_R10U;
  logic            validTri_R10H;
  logic [47:0]     screen_RnnnnS;
  logic [3:0]      subSample_RnnnnU;
  logic            busy_H;
  logic [31:0]     tri_count;
  state_e          dbg_state;

  int checks = 0;
  int failures = 0;

  logic [TW-1:0] t0, t1;
  logic [CW-1:0] c0, c1;

  typedef struct {
    logic [1:0] rv;
    logic       halt;
    logic       cfg;
    logic [1:0] rdy;
    logic       vld;
    logic       src;
    int         cnt;
    logic       ack;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  rast_tri_sched dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_tri          (req_tri),
    .req_color        (req_color),
    .req_ready        (req_ready),
    .cfg_req          (cfg_req),
    .cfg_screen       (cfg_screen),
    .cfg_subsample    (cfg_subsample),
    .cfg_ack          (cfg_ack),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R10S         (tri_R10S),
    .color_R10U       (color_R10U),
    .validTri_R10H    (validTri_R10H),
    .screen_RnnnnS    (screen_RnnnnS),
    .subSample_RnnnnU (subSample_RnnnnU),
    .busy_H           (busy_H),
    .tri_count        (tri_count),
    .dbg_state        (dbg_state)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic halt, input logic cfg);
    req_valid   = rv;
    halt_RnnnnL = halt;
    cfg_req     = cfg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] rv, input logic halt, input logic cfg,
                              input logic [1:0] rdy, input logic vld, input logic src,
                              input int cnt, input logic ack);
    vec_t v;
    v.rv = rv; v.halt = halt; v.cfg = cfg; v.rdy = rdy;
    v.vld = vld; v.src = src; v.cnt = cnt; v.ack = ack;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},  256'(validTri_R10H), 256'(0));
    chk({tag, "_tri"},    256'(tri_R10S), 256'(0));
    chk({tag, "_color"},  256'(color_R10U), 256'(0));
    chk({tag, "_ready"},  256'(req_ready), 256'(0));
    chk({tag, "_ack"},    256'(cfg_ack), 256'(0));
    chk({tag, "_screen"}, 256'(screen_RnnnnS), 256'(SCR_DEF));
    chk({tag, "_sub"},    256'(subSample_RnnnnU), 256'(4'b1000));
    chk({tag, "_count"},  256'(tri_count), 256'(0));
    chk({tag, "_busy"},   256'(busy_H), 256'(0));
    chk({tag, "_state"},  256'(dbg_state), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at;
    logic [447:0] rnd;

    for (int k = 0; k < 9; k++) begin
      t0[k*24 +: 24] = 24'h100000 + 24'(k);
      t1[k*24 +: 24] = 24'hF00000 + 24'(k);
    end
    for (int k = 0; k < 3; k++) begin
      c0[k*24 +: 24] = 24'h0000A0 + 24'(k);
      c1[k*24 +: 24] = 24'h0000B0 + 24'(k);
    end

    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    req_tri       = {t1, t0};
    req_color     = {c1, c0};
    cfg_screen    = SCR_DEF;
    cfg_subsample = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("init");
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();

    // Fairness, collision with pointer preserved, drain and resume.
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(2'b11, 1, 0, (k % 2 == 0) ? 2'b01 : 2'b10, 1, 1'(k % 2), k, 0));
    vecs.push_back(mk(2'b01, 1, 0, 2'b01, 1, 0, 10, 0));
    vecs.push_back(mk(2'b11, 1, 1, 2'b00, 0, 0, 11, 0));
    for (int k = 12; k < 20; k++)
      vecs.push_back(mk(2'b11, 1, 1, 2'b00, 0, 0, 11, 0));
    vecs.push_back(mk(2'b11, 1, 1, 2'b00, 0, 0, 11, 1));
    vecs.push_back(mk(2'b11, 1, 0, 2'b00, 0, 0, 11, 0));
    vecs.push_back(mk(2'b11, 1, 0, 2'b10, 1, 1, 11, 0));
    vecs.push_back(mk(2'b11, 1, 0, 2'b01, 1, 0, 12, 0));

    foreach (vecs[n]) begin
      drive(vecs[n].rv, vecs[n].halt, vecs[n].cfg);
      #1;
      chk($sformatf("vec%0d_ready", n), 256'(req_ready), 256'(vecs[n].rdy));
      tick();
      chk($sformatf("vec%0d_valid", n), 256'(validTri_R10H), 256'(vecs[n].vld));
      if (vecs[n].vld) begin
        chk($sformatf("vec%0d_tri", n), 256'(tri_R10S), 256'(vecs[n].src ? t1 : t0));
        chk($sformatf("vec%0d_color", n), 256'(color_R10U), 256'(vecs[n].src ? c1 : c0));
      end
      chk($sformatf("vec%0d_count", n), 256'(tri_count), 256'(vecs[n].cnt));
      chk($sformatf("vec%0d_ack", n), 256'(cfg_ack), 256'(vecs[n].ack));
    end

    // Backpressure: R10 holds t0 while inputs churn.
    drive(2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 14; j++) rnd[j*32 +: 32] = $urandom();
      req_tri = rnd[2*TW-1:0];
      #1;
      chk("bp_ready", 256'(req_ready), 256'(0));
      tick();
      chk("bp_tri", 256'(tri_R10S), 256'(t0));
      chk("bp_valid", 256'(validTri_R10H), 256'(1));
      chk("bp_count", 256'(tri_count), 256'(12));
    end
    req_tri = {t1, t0};
    drive(2'b00, 1'b1, 1'b0);
    tick();
    chk("bp_accept_count", 256'(tri_count), 256'(13));
    chk("bp_accept_valid", 256'(validTri_R10H), 256'(0));

    // Config drain after a long stall.
    drive(2'b00, 1'b0, 1'b0);
    repeat (50) tick();
    chk("stall_busy", 256'(busy_H), 256'(1));
    chk("stall_count", 256'(tri_count), 256'(13));
    cfg_screen    = SCR_A;
    cfg_subsample = 4'b0100;
    drive(2'b11, 1'b0, 1'b1);
    #1;
    chk("cfg_collide_ready", 256'(req_ready), 256'(0));
    tick();
    chk("drain_state", 256'(dbg_state), 256'(1));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_halt_ready", 256'(req_ready), 256'(0));
      tick();
      chk("drain_halt_ack", 256'(cfg_ack), 256'(0));
    end
    drive(2'b11, 1'b1, 1'b1);
    at = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk("drain_ready", 256'(req_ready), 256'(0));
      tick();
      if (cfg_ack) begin
        at = k;
        break;
      end
    end
    chk("drain_ack_latency", 256'(at), 256'(9));
    chk("drain_screen_old", 256'(screen_RnnnnS), 256'(SCR_DEF));
    drive(2'b00, 1'b1, 1'b0);
    tick();
    chk("drain_screen_new", 256'(screen_RnnnnS), 256'(SCR_A));
    chk("drain_sub_new", 256'(subSample_RnnnnU), 256'(4'b0100));
    chk("drain_ack_drop", 256'(cfg_ack), 256'(0));
    chk("drain_state_run", 256'(dbg_state), 256'(0));

    // Idle config: ack exactly two cycles after the request.
    cfg_screen    = SCR_B;
    cfg_subsample = 4'b0001;
    drive(2'b00, 1'b1, 1'b1);
    tick();
    chk("idle_ack_c1", 256'(cfg_ack), 256'(0));
    tick();
    chk("idle_ack_c2", 256'(cfg_ack), 256'(1));
    drive(2'b00, 1'b1, 1'b0);
    tick();
    chk("idle_sub", 256'(subSample_RnnnnU), 256'(4'b0001));
    chk("idle_screen", 256'(screen_RnnnnS), 256'(SCR_B));
    chk("idle_busy", 256'(busy_H), 256'(0));

    // Reset mid-stream with a triangle held on R10.
    drive(2'b01, 1'b0, 1'b0);
    tick();
    chk("pre_reset_valid", 256'(validTri_R10H), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk) rst_n = 1'b1;
    drive(2'b00, 1'b0, 1'b0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
